// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: per-stage stall arbitration, exception and
// ERET redirect, multi-cycle flush hold and a stall-duration watchdog.
module pipeline_hazard_ctrl #(
  parameter int unsigned       STAGES     = 6,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       EXC_W      = 32,
  parameter logic [EXC_W-1:0]  ERET_CODE  = EXC_W'(32'h0000000e),
  parameter logic [ADDR_W-1:0] VEC_OFFSET = ADDR_W'(32'h00000180),
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = ADDR_W'(32'h80000000),
  parameter int unsigned       FLUSH_HOLD = 1,
  parameter int unsigned       WDOG_MAX   = 1023,
  localparam int unsigned      CNT_W      = $clog2(WDOG_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic [EXC_W-1:0]  exc_type_i,
  input  logic              tlbmiss_i,
  input  logic [ADDR_W-1:0] epc_i,
  input  logic [ADDR_W-1:0] ebase_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] exc_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              wdog_o
);

  localparam int unsigned HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_MAX);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [ADDR_W-1:0] addr_lat, addr_nxt;
  logic [ADDR_W-1:0] exc_tgt;
  logic [CNT_W-1:0]  stall_cnt;

  // Output decode and next-state: flush hold, exception priority, stall OR-chain.
  always_comb begin
    stall_o    = '0;
    flush_o    = 1'b0;
    redirect_o = 1'b0;
    exc_addr_o = IDLE_ADDR;
    state_nxt  = state;
    hold_nxt   = hold;
    addr_nxt   = addr_lat;
    exc_tgt    = IDLE_ADDR;
    if (rst) begin
      if (state == ST_FLUSH) begin
        flush_o    = 1'b1;
        exc_addr_o = addr_lat;
        hold_nxt   = hold - HOLD_W'(1);
        if (hold <= HOLD_W'(1)) begin
          state_nxt = ST_RUN;
        end
      end else if (tlbmiss_i || (exc_type_i != '0)) begin
        if (tlbmiss_i) begin
          exc_tgt = ebase_i;
        end else if (exc_type_i == ERET_CODE) begin
          exc_tgt = epc_i;
        end else begin
          exc_tgt = ebase_i + VEC_OFFSET;
        end
        flush_o    = 1'b1;
        redirect_o = 1'b1;
        exc_addr_o = exc_tgt;
        if (FLUSH_HOLD > 1) begin
          addr_nxt  = exc_tgt;
          hold_nxt  = HOLD_W'(FLUSH_HOLD - 1);
          state_nxt = ST_FLUSH;
        end
      end else begin
        for (int unsigned j = 0; j < STAGES; j++) begin
          stall_o[j] = |(stall_req_i >> j);
        end
      end
    end
  end

  // State, flush hold counter and latched redirect address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      hold     <= '0;
      addr_lat <= IDLE_ADDR;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      addr_lat <= addr_nxt;
    end
  end

  // Consecutive-stall counter with sticky watchdog; stall_o is already zero
  // in FLUSH and exception cycles, so it alone decides increment vs clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      wdog_o    <= 1'b0;
    end else if (stall_o != '0) begin
      if (stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (stall_cnt >= CNT_MAX - CNT_W'(1)) begin
        wdog_o <= 1'b1;
      end
    end else begin
      stall_cnt <= '0;
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (STAGES=6, FLUSH_HOLD=3, WDOG_MAX=5).
module tb_pipeline_hazard_ctrl;

  localparam int FH   = 3;
  localparam int WMAX = 5;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_req;
  logic [31:0] exc_type;
  logic        tlbmiss;
  logic [31:0] epc;
  logic [31:0] ebase;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] exc_addr_o;
  logic [2:0]  stall_cnt_o;
  logic        wdog_o;

  int checks;
  int failures;

  // reference model state
  int          m_left;
  logic [31:0] m_addr;
  int          m_cnt;
  logic        m_wdog;

  // predicted outputs for the current cycle
  logic [5:0]  e_stall;
  logic        e_flush;
  logic        e_redir;
  logic [31:0] e_addr;
  logic        e_exc;

  pipeline_hazard_ctrl #(
    .STAGES    (6),
    .ADDR_W    (32),
    .EXC_W     (32),
    .ERET_CODE (32'h0000000e),
    .VEC_OFFSET(32'h00000180),
    .IDLE_ADDR (32'h80000000),
    .FLUSH_HOLD(FH),
    .WDOG_MAX  (WMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_req_i(stall_req),
    .exc_type_i (exc_type),
    .tlbmiss_i  (tlbmiss),
    .epc_i      (epc),
    .ebase_i    (ebase),
    .stall_o    (stall_o),
    .flush_o    (flush_o),
    .redirect_o (redirect_o),
    .exc_addr_o (exc_addr_o),
    .stall_cnt_o(stall_cnt_o),
    .wdog_o     (wdog_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_left = 0;
    m_addr = 32'h80000000;
    m_cnt  = 0;
    m_wdog = 1'b0;
  endtask

  // Expected outputs from the behavioural rules given current inputs.
  task automatic predict();
    e_stall = '0;
    e_flush = 1'b0;
    e_redir = 1'b0;
    e_addr  = 32'h80000000;
    e_exc   = 1'b0;
    if (m_left > 0) begin
      e_flush = 1'b1;
      e_addr  = m_addr;
    end else if (tlbmiss || exc_type != 0) begin
      e_exc   = 1'b1;
      e_flush = 1'b1;
      e_redir = 1'b1;
      if (tlbmiss) e_addr = ebase;
      else if (exc_type == 32'h0e) e_addr = epc;
      else e_addr = ebase + 32'h180;
    end else begin
      for (int k = 0; k < 6; k++)
        if (stall_req[k]) e_stall = 6'((1 << (k + 1)) - 1);
    end
  endtask

  // Clock edge, then commit the model's next state.
  task automatic advance();
    @(posedge clk);
    #1;
    if (m_left > 0) begin
      m_left = m_left - 1;
      m_cnt  = 0;
    end else if (e_exc) begin
      m_left = FH - 1;
      m_addr = e_addr;
      m_cnt  = 0;
    end else if (e_stall != 0) begin
      if (m_cnt < WMAX) m_cnt = m_cnt + 1;
      if (m_cnt == WMAX) m_wdog = 1'b1;
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic idle_inputs();
    stall_req = '0;
    exc_type  = '0;
    tlbmiss   = 1'b0;
    epc       = 32'h80000444;
    ebase     = 32'h80001000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    stall_req = 6'b111111;
    exc_type  = 32'd8;
    #3;
    checks++;
    if ({stall_o, flush_o, redirect_o, exc_addr_o, stall_cnt_o, wdog_o} !==
        {6'b0, 1'b0, 1'b0, 32'h80000000, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got stall=%b flush=%b redir=%b addr=%h cnt=%0d wdog=%b exp 0/0/0/80000000/0/0",
               stall_o, flush_o, redirect_o, exc_addr_o, stall_cnt_o, wdog_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({stall_o, flush_o, exc_addr_o, stall_cnt_o} !== {6'b0, 1'b0, 32'h80000000, 3'd0}) begin
      failures++;
      $display("FAIL reset_after_edge: got stall=%b flush=%b addr=%h cnt=%0d exp 0/0/80000000/0",
               stall_o, flush_o, exc_addr_o, stall_cnt_o);
    end
    idle_inputs();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_stall_priority();
    logic [5:0] reqs [3];
    logic [5:0] exps [3];
    reqs = '{6'b010000, 6'b000010, 6'b001100};
    exps = '{6'b011111, 6'b000011, 6'b001111};
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      stall_req = reqs[i];
      #1;
      predict();
      checks++;
      if ({stall_o, flush_o, redirect_o, exc_addr_o} !== {exps[i], 1'b0, 1'b0, 32'h80000000}) begin
        failures++;
        $display("FAIL stall_prio[%0d]: got stall=%b flush=%b redir=%b addr=%h exp stall=%b flush=0 redir=0 addr=80000000",
                 i, stall_o, flush_o, redirect_o, exc_addr_o, exps[i]);
      end
      checks++;
      if ({stall_cnt_o, wdog_o} !== {3'(m_cnt), m_wdog}) begin
        failures++;
        $display("FAIL stall_prio_cnt[%0d]: got cnt=%0d wdog=%b exp cnt=%0d wdog=%b",
                 i, stall_cnt_o, wdog_o, m_cnt, m_wdog);
      end
      advance();
    end
    idle_inputs();
    advance_idle();
  endtask

  task automatic advance_idle();
    for (int i = 0; i < FH + 1; i++) begin
      #1;
      predict();
      advance();
    end
  endtask

  task automatic test_exc_vectors();
    logic [31:0] ty [4];
    logic        tm [4];
    logic [31:0] eb [4];
    logic [31:0] ex [4];
    ty = '{32'd8, 32'h0e, 32'h0e, 32'd4};
    tm = '{1'b0, 1'b0, 1'b1, 1'b0};
    eb = '{32'h80001000, 32'h80001000, 32'h80001000, 32'hFFFFFF00};
    ex = '{32'h80001180, 32'h80000444, 32'h80001000, 32'h00000080};
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      exc_type  = ty[i];
      tlbmiss   = tm[i];
      ebase     = eb[i];
      stall_req = 6'b100000;
      #1;
      predict();
      checks++;
      if ({stall_o, flush_o, redirect_o, exc_addr_o} !== {6'b0, 1'b1, 1'b1, ex[i]} ||
          exc_addr_o !== e_addr) begin
        failures++;
        $display("FAIL exc_vec[%0d]: got stall=%b flush=%b redir=%b addr=%h exp stall=0 flush=1 redir=1 addr=%h",
                 i, stall_o, flush_o, redirect_o, exc_addr_o, ex[i]);
      end
      advance();
      idle_inputs();
      advance_idle();
    end
  endtask

  task automatic test_flush_hold();
    logic [31:0] first_addr;
    idle_inputs();
    exc_type = 32'd4;
    for (int c = 0; c < FH + 1; c++) begin
      if (c > 0) begin
        ebase     = 32'h90000000;
        exc_type  = (c < FH) ? 32'd8 : 32'd0;
        stall_req = 6'b111111;
      end
      #1;
      predict();
      if (c == 0) first_addr = exc_addr_o;
      checks++;
      if ({stall_o, flush_o, redirect_o, exc_addr_o} !== {e_stall, e_flush, e_redir, e_addr}) begin
        failures++;
        $display("FAIL flush_hold[%0d]: got stall=%b flush=%b redir=%b addr=%h exp stall=%b flush=%b redir=%b addr=%h",
                 c, stall_o, flush_o, redirect_o, exc_addr_o, e_stall, e_flush, e_redir, e_addr);
      end
      checks++;
      if (c < FH ? ({flush_o, redirect_o, stall_o, exc_addr_o} !== {1'b1, c == 0, 6'b0, 32'h80001180})
                 : ({flush_o, stall_o} !== {1'b0, 6'b111111})) begin
        failures++;
        $display("FAIL flush_hold_fixed[%0d]: got flush=%b redir=%b stall=%b addr=%h (first addr %h)",
                 c, flush_o, redirect_o, stall_o, exc_addr_o, first_addr);
      end
      advance();
    end
    idle_inputs();
    advance_idle();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int c = 0; c < 2 * FH + 1; c++) begin
      exc_type = (c == 0 || c == FH) ? 32'h0e : 32'd0;
      epc      = 32'h80000400 + 32'(c);
      #1;
      predict();
      checks++;
      if ({stall_o, flush_o, redirect_o, exc_addr_o} !== {e_stall, e_flush, e_redir, e_addr}) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got stall=%b flush=%b redir=%b addr=%h exp stall=%b flush=%b redir=%b addr=%h",
                 c, stall_o, flush_o, redirect_o, exc_addr_o, e_stall, e_flush, e_redir, e_addr);
      end
      advance();
    end
  endtask

  task automatic test_watchdog();
    idle_inputs();
    for (int c = 0; c < 14; c++) begin
      stall_req = ((c < 4) || (c >= 5 && c < 11)) ? 6'b001000 : 6'b000000;
      #1;
      predict();
      checks++;
      if ({stall_o, stall_cnt_o, wdog_o} !== {e_stall, 3'(m_cnt), m_wdog}) begin
        failures++;
        $display("FAIL watchdog[%0d]: got stall=%b cnt=%0d wdog=%b exp stall=%b cnt=%0d wdog=%b",
                 c, stall_o, stall_cnt_o, wdog_o, e_stall, m_cnt, m_wdog);
      end
      advance();
    end
    checks++;
    if ({stall_cnt_o, wdog_o} !== {3'd0, 1'b1}) begin
      failures++;
      $display("FAIL watchdog_sticky: got cnt=%0d wdog=%b exp cnt=0 wdog=1", stall_cnt_o, wdog_o);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    exc_type = 32'd4;
    #1;
    predict();
    advance();
    exc_type = 32'd0;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_o, flush_o, redirect_o, exc_addr_o, stall_cnt_o, wdog_o} !==
        {6'b0, 1'b0, 1'b0, 32'h80000000, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got stall=%b flush=%b redir=%b addr=%h cnt=%0d wdog=%b exp 0/0/0/80000000/0/0",
               stall_o, flush_o, redirect_o, exc_addr_o, stall_cnt_o, wdog_o);
    end
    model_reset();
    #1;
    rst = 1'b1;
    stall_req = 6'b000001;
    #1;
    predict();
    checks++;
    if ({stall_o, flush_o, exc_addr_o} !== {6'b000001, 1'b0, 32'h80000000} || stall_o !== e_stall) begin
      failures++;
      $display("FAIL after_reset: got stall=%b flush=%b addr=%h exp stall=000001 flush=0 addr=80000000",
               stall_o, flush_o, exc_addr_o);
    end
    advance();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 300; c++) begin
      stall_req = ($urandom_range(0, 2) == 0) ? 6'b0 : 6'($urandom);
      tlbmiss   = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 19))
        0:       exc_type = 32'd4;
        1:       exc_type = 32'h0e;
        2:       exc_type = $urandom;
        default: exc_type = 32'd0;
      endcase
      epc   = $urandom;
      ebase = $urandom;
      #1;
      predict();
      checks++;
      if ({stall_o, flush_o, redirect_o, exc_addr_o, stall_cnt_o, wdog_o} !==
          {e_stall, e_flush, e_redir, e_addr, 3'(m_cnt), m_wdog}) begin
        failures++;
        $display("FAIL random[%0d]: got stall=%b flush=%b redir=%b addr=%h cnt=%0d wdog=%b exp stall=%b flush=%b redir=%b addr=%h cnt=%0d wdog=%b",
                 c, stall_o, flush_o, redirect_o, exc_addr_o, stall_cnt_o, wdog_o,
                 e_stall, e_flush, e_redir, e_addr, m_cnt, m_wdog);
      end
      advance();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_stall_priority();
    test_exc_vectors();
    test_flush_hold();
    test_back_to_back();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
